bank_queue: RTL and testbench

BANK_QUEUE -- requirements
Module: bank_queue

---
 rtl/bank_queue_if.sv | 32 +++
 rtl/bank_queue.sv | 85 ++++++++
 tb/tb_bank_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bank_queue_if.sv
// Purpose: request/response bundle between a bank queue, its mapper and its scheduler.
// Latency: n/a (wires only).
// Backpressure: the mapper watches out_busy; the scheduler pops with out_ready.
// Ports: in_* push side, out_* head/pop side, count and overflow status.
interface bank_queue_if #(
    parameter int DEPTH_LOG = 3
);
    logic                 in_valid;
    logic [5:0]           in_index;
    logic                 in_type;
    logic [15:0]          in_row;
    logic                 out_busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           out_index;
    logic                 out_type;
    logic [15:0]          out_row;
    logic [DEPTH_LOG:0]   count;
    logic                 overflow;

    // mapper/scheduler side
    modport master (
        output in_valid, in_index, in_type, in_row, out_ready,
        input  out_busy, out_valid, out_index, out_type, out_row, count, overflow
    );

    // queue side
    modport slave (
        input  in_valid, in_index, in_type, in_row, out_ready,
        output out_busy, out_valid, out_index, out_type, out_row, count, overflow
    );
endinterface

// File: rtl/bank_queue.sv
// Purpose: per-bank in-order request FIFO between the address mapper and the bank scheduler.
// Latency: 1 cycle push-to-head, no bypass while empty.
// Backpressure: out_busy raised early from registered count; a push while full with no pop is dropped and flags sticky overflow.
// Ports: clk, rst (sync active-high), bq (slave side of bank_queue_if: push fields, head fields, count, overflow).
module bank_queue #(
    parameter int DEPTH       = 8,
    parameter int DEPTH_LOG   = 3,
    parameter int BUSY_MARGIN = 2
) (
    input  logic         clk,
    input  logic         rst,
    bank_queue_if.slave  bq
);
    localparam int CW = DEPTH_LOG + 1;
    localparam logic [DEPTH_LOG:0] FULL_CNT = CW'(DEPTH);
    localparam logic [DEPTH_LOG:0] BUSY_CNT = CW'(DEPTH - BUSY_MARGIN);

    typedef struct packed {
        logic [5:0]  index;
        logic        kind;
        logic [15:0] row;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   count_q;
    logic                 overflow_q;

    logic   not_empty;
    logic   full;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t head;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty && bq.out_ready;
    // a full queue can still accept when the head leaves in the same cycle
    assign push      = bq.in_valid && (!full || pop);
    assign drop      = bq.in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // storage is not reset; stale contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{index: bq.in_index, kind: bq.in_type, row: bq.in_row};
        end
    end

    assign head = not_empty ? mem[rd_ptr] : '0;

    assign bq.out_valid = not_empty;
    assign bq.out_index = head.index;
    assign bq.out_type  = head.kind;
    assign bq.out_row   = head.row;
    assign bq.count     = count_q;
    assign bq.overflow  = overflow_q;
    // threshold leaves headroom for pushes already in flight from the mapper
    assign bq.out_busy  = (count_q >= BUSY_CNT);
endmodule

// File: tb/tb_bank_queue.sv
module tb_bank_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   mcount;
    logic [22:0] exp_q [$];

    bank_queue_if #(.DEPTH_LOG(3)) bq ();

    bank_queue #(
        .DEPTH      (8),
        .DEPTH_LOG  (3),
        .BUSY_MARGIN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bq  (bq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: compares every popped head against the scoreboard
    always @(negedge clk) begin
        if (!rst && bq.out_valid && bq.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none",
                         {bq.out_index, bq.out_type, bq.out_row});
            end else begin
                if ({bq.out_index, bq.out_type, bq.out_row} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_data actual=%0h expected=%0h",
                             {bq.out_index, bq.out_type, bq.out_row}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        mcount = 0;
    endtask

    // one cycle of optional push and optional pop
    task automatic op(input logic do_push, input logic [5:0] idx, input logic do_pop);
        logic pop_ok;
        logic accept;
        logic [15:0] row;
        pop_ok = do_pop && (mcount > 0);
        accept = do_push && ((mcount < 8) || pop_ok);
        row = 16'h1000 + 16'(idx);
        bq.in_valid  = do_push;
        bq.in_index  = idx;
        bq.in_type   = idx[0];
        bq.in_row    = row;
        bq.out_ready = do_pop;
        if (accept) exp_q.push_back({idx, idx[0], row});
        mcount = mcount + int'(accept) - int'(pop_ok);
        step();
        bq.in_valid  = 1'b0;
        bq.out_ready = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && mcount > 0; k++) op(1'b0, 6'd0, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mcount = 0;
        rst = 1'b1;
        bq.in_valid = 1'b0;
        bq.in_index = '0;
        bq.in_type = 1'b0;
        bq.in_row = '0;
        bq.out_ready = 1'b0;
        step();
        do_reset();

        // reset state
        chk("rst_count", 32'(bq.count), 0);
        chk("rst_valid", 32'(bq.out_valid), 0);
        chk("rst_busy", 32'(bq.out_busy), 0);
        chk("rst_overflow", 32'(bq.overflow), 0);
        chk("rst_head_zero", {bq.out_index, bq.out_type, bq.out_row}, 0);

        // single push with explicit fields
        bq.in_valid = 1'b1;
        bq.in_index = 6'd5;
        bq.in_type = 1'b0;
        bq.in_row = 16'h1234;
        exp_q.push_back({6'd5, 1'b0, 16'h1234});
        mcount = 1;
        step();
        bq.in_valid = 1'b0;
        chk("first_valid", 32'(bq.out_valid), 1);
        chk("first_index", 32'(bq.out_index), 5);
        chk("first_row", 32'(bq.out_row), 32'h1234);
        chk("first_count", 32'(bq.count), 1);
        op(1'b0, 6'd0, 1'b1);
        chk("empty_count", 32'(bq.count), 0);
        chk("empty_head_zero", {bq.out_index, bq.out_type, bq.out_row}, 0);

        // busy threshold and overflow
        for (int i = 0; i < 5; i++) op(1'b1, 6'(10 + i), 1'b0);
        chk("count5", 32'(bq.count), 5);
        chk("busy5", 32'(bq.out_busy), 0);
        op(1'b1, 6'd15, 1'b0);
        chk("count6", 32'(bq.count), 6);
        chk("busy6", 32'(bq.out_busy), 1);
        op(1'b1, 6'd16, 1'b0);
        op(1'b1, 6'd17, 1'b0);
        chk("count8", 32'(bq.count), 8);
        chk("ovf_before_drop", 32'(bq.overflow), 0);
        op(1'b1, 6'd63, 1'b0);
        chk("count_after_drop", 32'(bq.count), 8);
        chk("ovf_after_drop", 32'(bq.overflow), 1);
        chk("head_after_drop", 32'(bq.out_index), 10);
        drain();
        chk("drain_count", 32'(bq.count), 0);
        chk("ovf_sticky", 32'(bq.overflow), 1);

        // full with simultaneous push and pop
        do_reset();
        chk("ovf_cleared", 32'(bq.overflow), 0);
        for (int i = 0; i < 8; i++) op(1'b1, 6'(20 + i), 1'b0);
        op(1'b1, 6'd28, 1'b1);
        chk("full_pp_count", 32'(bq.count), 8);
        chk("full_pp_ovf", 32'(bq.overflow), 0);
        chk("full_pp_head", 32'(bq.out_index), 21);
        drain();
        chk("full_pp_drained", 32'(bq.count), 0);

        // interleaved traffic across pointer wrap
        for (int i = 0; i < 20; i++) op(1'b1, 6'(i), (i % 3) != 0);
        chk("interleave_count", 32'(bq.count), 32'(mcount));
        drain();
        chk("interleave_drained", 32'(bq.count), 0);

        // reset mid-operation with a push pending
        for (int i = 0; i < 4; i++) op(1'b1, 6'(40 + i), 1'b0);
        chk("pre_rst_count", 32'(bq.count), 4);
        rst = 1'b1;
        bq.in_valid = 1'b1;
        bq.in_index = 6'd50;
        step();
        rst = 1'b0;
        bq.in_valid = 1'b0;
        exp_q.delete();
        mcount = 0;
        chk("midrst_count", 32'(bq.count), 0);
        chk("midrst_valid", 32'(bq.out_valid), 0);
        chk("midrst_busy", 32'(bq.out_busy), 0);
        step();
        chk("midrst_push_ignored", 32'(bq.count), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
